rpn_stack_ctrl: RTL and testbench

//  Command sequencer for the RPN calculator datapath: owns the operand stack and the 8-bit ALU.

---
 rtl/rpn_stack_ctrl_pkg.sv | 21 ++
 rtl/rpn_stack_ctrl_if.sv | 25 ++
 rtl/rpn_stack_ctrl_key_edge.sv | 27 ++
 rtl/rpn_stack_ctrl.sv | 148 ++++++++++++++
 tb/tb_rpn_stack_ctrl.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/rpn_stack_ctrl_pkg.sv
// RPN calculator shared types.
// Op codes, FSM states and default width.
package rpn_pkg;

  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_MUL  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10,
    S_WRITE = 2'b11
  } state_e;

endpackage

// File: rtl/rpn_stack_ctrl_if.sv
// Key/switch inputs and status outputs
// between the rpn top level and the stack sequencer.
interface rpn_stack_ctrl_if #(
  parameter int DW      = 8,
  parameter int DEPTH_W = 3
);
  logic             enter_n;
  logic [1:0]       op;
  logic [DW-1:0]    din;
  logic [DW-1:0]    tos;
  logic [DEPTH_W:0] depth;
  logic             busy;
  logic             err_under;
  logic             err_over;

  modport master (
    output enter_n, op, din,
    input  tos, depth, busy, err_under, err_over
  );

  modport slave (
    input  enter_n, op, din,
    output tos, depth, busy, err_under, err_over
  );
endinterface

// File: rtl/rpn_stack_ctrl_key_edge.sv
// ENTER key synchroniser.
// Emits one strobe per press on synced 1->0.
module rpn_key_edge (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_n,
  output logic pulse
);

  logic s1_q, s2_q, s3_q;

  // two sync flops plus one delay flop for edge detect
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= key_n;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign pulse = s3_q & ~s2_q;

endmodule

// File: rtl/rpn_stack_ctrl.sv
// RPN command sequencer: operand stack + ALU.
// Push or binary op per ENTER press.
module rpn_stack_ctrl
  import rpn_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DW      = DW_DEF,
  parameter int DEPTH_W = 3
) (
  input logic              CLOCK_50,
  input logic              reset,
  rpn_stack_ctrl_if.slave  bus
);

  localparam logic [DEPTH_W:0] FULL = (DEPTH_W+1)'(DEPTH);
  localparam logic [DEPTH_W:0] ONE  = (DEPTH_W+1)'(1);
  localparam logic [DEPTH_W:0] TWO  = (DEPTH_W+1)'(2);

  state_e           state_q, state_d;
  logic [DW-1:0]    stack_q [DEPTH];
  logic [DEPTH_W:0] depth_q;
  logic [DW-1:0]    tos_q, a_q, b_q, r_q;
  op_e              op_q;
  logic             err_under_q, err_over_q;

  logic             strobe;
  op_e              op_in;
  logic [DEPTH_W:0] dm1, dm2;
  logic [DEPTH_W-1:0] push_ix, top_ix, sec_ix;
  logic             do_push, do_over, do_under, do_start;
  logic             busy;

  rpn_key_edge u_key (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .key_n    (bus.enter_n),
    .pulse    (strobe)
  );

  assign op_in   = op_e'(bus.op);
  assign dm1     = depth_q - ONE;
  assign dm2     = depth_q - TWO;
  assign push_ix = depth_q[DEPTH_W-1:0];
  assign top_ix  = dm1[DEPTH_W-1:0];
  assign sec_ix  = dm2[DEPTH_W-1:0];

  // FSM state register
  always_ff @(posedge CLOCK_50) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: one pass FETCH->EXEC->WRITE per op
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (do_start) state_d = S_FETCH;
      S_FETCH: state_d = S_EXEC;
      S_EXEC:  state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: command decode in IDLE, busy otherwise
  always_comb begin
    do_push  = 1'b0;
    do_over  = 1'b0;
    do_under = 1'b0;
    do_start = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (strobe) begin
          if (op_in == OP_PUSH) begin
            do_push = (depth_q != FULL);
            do_over = (depth_q == FULL);
          end else begin
            do_under = (depth_q < TWO);
            do_start = (depth_q >= TWO);
          end
        end
      end
      default: busy = 1'b1;
    endcase
  end

  // stack storage; entries above depth are left stale
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      if (do_push)
        stack_q[push_ix] <= bus.din;
      else if (state_q == S_WRITE)
        stack_q[sec_ix] <= r_q;
    end
  end

  // depth, tos view, operands, ALU and error flags
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      depth_q     <= '0;
      tos_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      op_q        <= OP_PUSH;
      err_under_q <= 1'b0;
      err_over_q  <= 1'b0;
    end else begin
      if (do_push || do_start) begin
        err_under_q <= 1'b0;
        err_over_q  <= 1'b0;
      end
      if (do_over)  err_over_q  <= 1'b1;
      if (do_under) err_under_q <= 1'b1;
      if (do_push) begin
        depth_q <= depth_q + ONE;
        tos_q   <= bus.din;
      end
      if (do_start) op_q <= op_in;
      unique case (state_q)
        S_FETCH: begin
          a_q <= stack_q[sec_ix];
          b_q <= stack_q[top_ix];
        end
        S_EXEC: begin
          unique case (op_q)
            OP_ADD:  r_q <= a_q + b_q;
            OP_SUB:  r_q <= a_q - b_q;
            OP_MUL:  r_q <= DW'(a_q * b_q);
            default: r_q <= a_q;
          endcase
        end
        S_WRITE: begin
          depth_q <= dm1;
          tos_q   <= r_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.tos       = tos_q;
  assign bus.depth     = depth_q;
  assign bus.busy      = busy;
  assign bus.err_under = err_under_q;
  assign bus.err_over  = err_over_q;

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Directed bench for rpn_stack_ctrl.
// Hand-computed stack/ALU results.
module tb_rpn_stack_ctrl;
  import rpn_pkg::*;

  logic clk;
  logic reset;
  int   errs;
  int   checks;

  rpn_stack_ctrl_if #(.DW(8), .DEPTH_W(3)) bus ();

  rpn_stack_ctrl #(.DEPTH(8), .DW(8), .DEPTH_W(3)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // press ENTER; returns with the strobe high, one edge before it acts
  task automatic press(input logic [1:0] o, input logic [7:0] d);
    @(negedge clk);
    bus.op      = o;
    bus.din     = d;
    bus.enter_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.enter_n = 1'b1;
  endtask

  task automatic push(input logic [7:0] d);
    press(2'b00, d);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_op(input logic [1:0] o);
    press(o, 8'h00);
    repeat (5) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    errs        = 0;
    checks      = 0;
    reset       = 1'b1;
    bus.enter_n = 1'b1;
    bus.op      = 2'b00;
    bus.din     = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_tos", bus.tos, 0);
    chk("rst_depth", bus.depth, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_eu", bus.err_under, 0);
    chk("rst_eo", bus.err_over, 0);

    press(2'b00, 8'hA9);
    chk("push_pre_depth", bus.depth, 0);
    @(negedge clk);
    chk("push_tos", bus.tos, 8'hA9);
    chk("push_depth", bus.depth, 1);
    chk("push_eu", bus.err_under, 0);
    chk("push_eo", bus.err_over, 0);
    repeat (2) @(negedge clk);

    pulse_reset();
    push(8'h09);
    push(8'h04);
    press(2'b10, 8'h00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("sub_busy%0d", i), bus.busy, (i < 3) ? 1 : 0);
    end
    chk("sub_tos", bus.tos, 8'h05);
    chk("sub_depth", bus.depth, 1);

    pulse_reset();
    push(8'hF0);
    push(8'h20);
    do_op(2'b01);
    chk("add_wrap", bus.tos, 8'h10);
    chk("add_depth", bus.depth, 1);
    push(8'h10);
    push(8'h10);
    do_op(2'b11);
    chk("mul_wrap", bus.tos, 8'h00);
    chk("mul_depth", bus.depth, 2);
    push(8'h07);
    do_op(2'b10);
    chk("sub_neg", bus.tos, 8'hF9);
    chk("sub_neg_depth", bus.depth, 2);

    pulse_reset();
    do_op(2'b01);
    chk("und_flag", bus.err_under, 1);
    chk("und_depth", bus.depth, 0);
    chk("und_busy", bus.busy, 0);
    push(8'h01);
    chk("und_clr", bus.err_under, 0);
    chk("und_tos", bus.tos, 8'h01);

    pulse_reset();
    for (int i = 1; i <= 8; i++) push(8'(i));
    chk("full_tos", bus.tos, 8'h08);
    chk("full_depth", bus.depth, 8);
    push(8'h55);
    chk("ovr_flag", bus.err_over, 1);
    chk("ovr_depth", bus.depth, 8);
    chk("ovr_tos", bus.tos, 8'h08);
    do_op(2'b01);
    chk("ovr_add", bus.tos, 8'h0F);
    chk("ovr_add_depth", bus.depth, 7);
    chk("ovr_clr", bus.err_over, 0);

    pulse_reset();
    @(negedge clk);
    bus.op      = 2'b00;
    bus.din     = 8'h77;
    bus.enter_n = 1'b0;
    repeat (20) @(negedge clk);
    bus.enter_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("hold_depth", bus.depth, 1);
    chk("hold_tos", bus.tos, 8'h77);

    pulse_reset();
    push(8'h02);
    push(8'h03);
    press(2'b11, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("exec_busy", bus.busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_depth", bus.depth, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_tos", bus.tos, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_idle", bus.busy, 0);
    push(8'h11);
    chk("after_tos", bus.tos, 8'h11);
    chk("after_depth", bus.depth, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
